// File: rtl/sobel_frame_ctrl_if.sv
// Handshake bundle between the frame controller, the pixel source, the Sobel
// datapath and the frame consumer.
interface sobel_frame_ctrl_if #(
    parameter int WIDTH  = 9,
    parameter int HEIGHT = 9
);
    logic                      start;
    logic                      pix_in;
    logic                      pix_valid;
    logic                      pix_ready;
    logic [8:0]                win;
    logic                      win_valid;
    logic                      edge_in;
    logic                      edge_valid;
    logic [WIDTH*HEIGHT-1:0]   bmp_out;
    logic                      frame_valid;
    logic                      frame_ack;
    logic                      busy;

    modport master (
        output start, pix_in, pix_valid, edge_in, edge_valid, frame_ack,
        input  pix_ready, win, win_valid, bmp_out, frame_valid, busy
    );

    modport slave (
        input  start, pix_in, pix_valid, edge_in, edge_valid, frame_ack,
        output pix_ready, win, win_valid, bmp_out, frame_valid, busy
    );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame controller: buffers a serial binary image, walks every interior 3x3
// window through the Sobel datapath and publishes the edge bitmap.
module sobel_frame_ctrl #(
    parameter int WIDTH  = 9,
    parameter int HEIGHT = 9
) (
    input  logic              dclk,
    input  logic              clr,
    sobel_frame_ctrl_if.slave bus
);
    localparam int N  = WIDTH * HEIGHT;
    localparam int IW = $clog2(N);
    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, LOAD, SCAN, WAIT, HOLD} state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   cnt_reg, cnt_next;
    logic [RW-1:0]   r_reg, r_next;
    logic [CW-1:0]   c_reg, c_next;
    logic [N-1:0]    frame_reg, frame_next;
    logic [N-1:0]    result_reg, result_next;
    logic [N-1:0]    bmp_reg;
    logic [8:0]      win_reg, win_next;
    logic            win_valid_reg;
    logic            pix_ready_reg;
    logic            frame_valid_reg;
    logic            busy_reg;
    logic [IW-1:0]   res_idx;
    logic [IW-1:0]   win_base;
    logic            last_window;

    assign res_idx     = IW'(int'(r_reg) * WIDTH + int'(c_reg));
    assign last_window = (r_reg == RW'(HEIGHT - 2)) && (c_reg == CW'(WIDTH - 2));

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        r_next      = r_reg;
        c_next      = c_reg;
        frame_next  = frame_reg;
        result_next = result_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = LOAD;
                    cnt_next   = '0;
                end
            end
            LOAD: begin
                if (bus.pix_valid) begin
                    frame_next[cnt_reg] = bus.pix_in;
                    cnt_next            = cnt_reg + IW'(1);
                    if (cnt_reg == IW'(N - 1)) begin
                        state_next = SCAN;
                        r_next     = RW'(1);
                        c_next     = CW'(1);
                    end
                end
            end
            SCAN: state_next = WAIT;
            WAIT: begin
                if (bus.edge_valid) begin
                    result_next[res_idx] = bus.edge_in;
                    if (last_window) begin
                        state_next = HOLD;
                    end else begin
                        state_next = SCAN;
                        if (c_reg == CW'(WIDTH - 2)) begin
                            c_next = CW'(1);
                            r_next = r_reg + RW'(1);
                        end else begin
                            c_next = c_reg + CW'(1);
                        end
                    end
                end
            end
            HOLD: begin
                if (bus.frame_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The window is gathered from the next-cycle frame and position so it is
    // already registered during the SCAN cycle (the last pixel may be in it).
    assign win_base = IW'((int'(r_next) - 1) * WIDTH + int'(c_next) - 1);

    for (genvar gi = 0; gi < 9; gi++) begin : g_win
        localparam logic [IW-1:0] OFF = IW'((gi / 3) * WIDTH + (gi % 3));
        assign win_next[gi] = frame_next[win_base + OFF];
    end

    always_ff @(posedge dclk) begin
        if (clr) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            r_reg           <= '0;
            c_reg           <= '0;
            frame_reg       <= '0;
            result_reg      <= '0;
            bmp_reg         <= '0;
            win_reg         <= '0;
            win_valid_reg   <= 1'b0;
            pix_ready_reg   <= 1'b0;
            frame_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            r_reg           <= r_next;
            c_reg           <= c_next;
            frame_reg       <= frame_next;
            result_reg      <= result_next;
            win_valid_reg   <= (state_next == SCAN);
            pix_ready_reg   <= (state_next == LOAD);
            frame_valid_reg <= (state_next == HOLD);
            busy_reg        <= (state_next != IDLE);
            if (state_next == SCAN) win_reg <= win_next;
            if (state_next == HOLD && state_reg != HOLD) bmp_reg <= result_next;
        end
    end

    assign bus.pix_ready   = pix_ready_reg;
    assign bus.win         = win_reg;
    assign bus.win_valid   = win_valid_reg;
    assign bus.bmp_out     = bmp_reg;
    assign bus.frame_valid = frame_valid_reg;
    assign bus.busy        = busy_reg;
endmodule

// File: doc/sobel_frame_ctrl.md
SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 9, meaning image columns (3 or more).
REQ-002 The block SHALL have parameter HEIGHT, default 9, meaning image rows (3 or more).
REQ-003 The block SHALL have port dclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port clr, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: begin a frame; sampled only in IDLE.
REQ-006 The block SHALL have port pix_in, input, 1 bit: serial binary pixel, row-major, top-left first.
REQ-007 The block SHALL have port pix_valid, input, 1 bit: pix_in is valid.
REQ-008 The block SHALL have port pix_ready, output, 1 bit: controller accepts a pixel this cycle.
REQ-009 The block SHALL have port win, output, 9 bits: 3x3 neighbourhood to the Sobel datapath.
REQ-010 The block SHALL have port win_valid, output, 1 bit: one-cycle window-issue strobe.
REQ-011 The block SHALL have port edge_in, input, 1 bit: datapath edge result.
REQ-012 The block SHALL have port edge_valid, input, 1 bit: edge_in is valid.
REQ-013 The block SHALL have port bmp_out, output, WIDTH*HEIGHT bits: result image for the VGA block, with bit r*WIDTH+c holding pixel (r,c).
REQ-014 The block SHALL have port frame_valid, output, 1 bit: bmp_out holds a complete frame.
REQ-015 The block SHALL have port frame_ack, input, 1 bit: consumer has taken the frame.
REQ-016 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 The block SHALL implement states IDLE, LOAD, SCAN, WAIT and HOLD.
REQ-018 In IDLE, start=1 SHALL move the block to LOAD and clear the pixel counter; all other inputs SHALL be ignored in IDLE.
REQ-019 In LOAD, pix_ready SHALL be 1, and each cycle with pix_valid=1 SHALL store pix_in at frame index cnt and increment cnt.
REQ-020 Acceptance of pixel index WIDTH*HEIGHT-1 SHALL move the block to SCAN with (r,c)=(1,1).
REQ-021 In SCAN, the block SHALL drive win[3*i+j] = frame[(r-1+i)*WIDTH+(c-1+j)] for i,j in 0..2, assert win_valid for exactly that cycle, and go to WAIT.
REQ-022 In WAIT, win_valid SHALL be 0, win SHALL hold its value, and the block SHALL stay in WAIT until edge_valid=1.
REQ-023 On edge_valid=1 in WAIT, the block SHALL write edge_in to result bit r*WIDTH+c.
REQ-024 On the same edge_valid, the block SHALL advance the scan position: if c<WIDTH-2 then c+1, else c=1 and r+1.
REQ-025 The advance SHALL return to SCAN, except that the last window (r=HEIGHT-2, c=WIDTH-2) SHALL go to HOLD.
REQ-026 edge_valid SHALL be ignored outside WAIT.
REQ-027 Border pixels (r=0, r=HEIGHT-1, c=0, c=WIDTH-1) SHALL never be issued to the datapath and SHALL read 0 in bmp_out.
REQ-028 bmp_out SHALL load the result image on entry to HOLD and SHALL change at no other time except reset.
REQ-029 In HOLD, frame_valid SHALL be 1 until frame_ack=1 is sampled; the block SHALL then go to IDLE, with frame_valid=0 on the following cycle.
REQ-030 start SHALL be ignored in all non-IDLE states, including when it coincides with frame_ack in HOLD.
REQ-031 Latency: with edge_valid returned in the first WAIT cycle, frame_valid SHALL rise 2*(WIDTH-2)*(HEIGHT-2)+1 cycles after the last pixel is accepted (99 cycles for 9x9).

Reset
REQ-032 clr=1 at a rising edge SHALL, in any state, force IDLE and clear the internal frame, result image, counters and bmp_out to 0.
REQ-033 The same reset SHALL force pix_ready, win, win_valid, frame_valid and busy to 0; reset mid-frame SHALL abandon the frame without producing output.

Verification
REQ-034 clr for 2 cycles mid-LOAD (40 pixels in) -> IDLE, pix_ready=0, busy=0, bmp_out=0, frame_valid=0; a new start reloads from index 0.
REQ-035 All-zero image, model edge_in=0 returned one cycle after win_valid -> 49 win_valid pulses; frame_valid=1 exactly 99 cycles after 81st pixel; bmp_out=0.
REQ-036 Model edge_in=1 always -> 49 interior bits of bmp_out=1 and 32 border bits=0.
REQ-037 Only pixel (4,4)=1 -> window (3,3) win=9'b100000000 and window (4,4) win=9'b000010000.
REQ-038 pix_valid alternating 1/0 plus edge_valid delayed 3 cycles and pulsed once during SCAN -> exactly 81 pixels taken, win stable through WAIT, SCAN pulse ignored, result unchanged vs REQ-035.
REQ-039 frame_ack low for 10 HOLD cycles with a start pulse -> frame_valid and bmp_out stable, start ignored; then ack=1 -> IDLE, frame_valid=0 next cycle.
